// File: rtl/id_stage_pipe.sv
// RV instruction-decode stage: register file, immediate generation, control decode,
// load-use hazard detection, JAL resolution and the ID/EX pipeline register.
// Latency: one cycle from ID inputs to the ex_* outputs. stall_out, jump_taken and jump_target are combinational.
// Backpressure: stall_out holds PC and IF/ID and inserts one bubble. ex_flush kills the instruction in ID.
//
// Ports:
//   clk, reset_n                      clock and async active-low reset
//   if_valid, if_pc, if_instr         instruction currently in ID
//   wb_we, wb_addr, wb_data           register-file write port from WB
//   ex_flush                          EX mispredict; squash the ID instruction
//   stall_out, jump_taken, jump_target  hazard stall and JAL redirect
//   ex_*                              ID/EX register contents
//   ctrl_wb {MemtoReg,RegWrite}, ctrl_m {MemRead,MemWrite}, ctrl_ex {ALUSrc,ALUOp[2:0]}

module id_stage_pipe #(
    parameter int XLEN      = 64,
    parameter int NREGS     = 32,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc,
    input  logic [31:0]     if_instr,
    input  logic            wb_we,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_flush,
    output logic            stall_out,
    output logic            jump_taken,
    output logic [XLEN-1:0] jump_target,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic            ex_mem_read,
    output logic [1:0]      ctrl_wb,
    output logic [1:0]      ctrl_m,
    output logic [3:0]      ctrl_ex,
    output logic            ex_illegal
);

    localparam int AW = $clog2(NREGS);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef struct packed {
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic [2:0] alu_op;
    } ctrl_t;

    function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    // ------------------------------------------------------------------
    // Instruction fields and immediates
    // ------------------------------------------------------------------
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;

    assign opcode = if_instr[6:0];
    assign rd     = if_instr[11:7];
    assign funct3 = if_instr[14:12];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
    assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                    if_instr[11:8], 1'b0};
    assign imm_u = {if_instr[31:12], 12'b0};
    assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                    if_instr[30:21], 1'b0};

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    ctrl_t       ctrl_d;
    logic        illegal_op;
    logic        uses_rs1;
    logic        uses_rs2;
    logic [31:0] imm_sel;
    logic [2:0]  r_alu_op;

    always_comb begin
        r_alu_op = ALU_ADD;
        case (funct3)
            3'b000:  r_alu_op = if_instr[30] ? ALU_SUB : ALU_ADD;
            3'b001:  r_alu_op = ALU_SLL;
            3'b010:  r_alu_op = ALU_SLT;
            3'b110:  r_alu_op = ALU_OR;
            3'b111:  r_alu_op = ALU_AND;
            default: r_alu_op = ALU_ADD;
        endcase
    end

    always_comb begin
        ctrl_d     = '0;
        illegal_op = 1'b0;
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b0;
        imm_sel    = '0;
        case (opcode)
            OP_R: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_op    = r_alu_op;
                uses_rs2         = 1'b1;
            end
            OP_IMM: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                imm_sel          = imm_i;
            end
            OP_LOAD: begin
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_read   = 1'b1;
                ctrl_d.alu_src    = 1'b1;
                imm_sel           = imm_i;
            end
            OP_STORE: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                uses_rs2         = 1'b1;
                imm_sel          = imm_s;
            end
            OP_BRANCH: begin
                ctrl_d.alu_op = ALU_SUB;
                uses_rs2      = 1'b1;
                imm_sel       = imm_b;
            end
            OP_JALR: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_src   = 1'b1;
                imm_sel          = imm_i;
            end
            OP_JAL: begin
                ctrl_d.reg_write = 1'b1;
                uses_rs1         = 1'b0;
                imm_sel          = imm_j;
            end
            OP_LUI, OP_AUIPC: begin
                // U-type immediates are generated but the opcodes are not executed here.
                illegal_op = 1'b1;
                uses_rs1   = 1'b0;
                imm_sel    = imm_u;
            end
            default: begin
                illegal_op = 1'b1;
                uses_rs1   = 1'b0;
            end
        endcase
    end

    // Only indices the instruction actually reads are range-checked, so that
    // immediate bits sitting in the rs2 field never raise a false illegal.
    logic bad_idx;
    assign bad_idx = (uses_rs1 && (int'(rs1) >= NREGS)) ||
                     (uses_rs2 && (int'(rs2) >= NREGS));

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we && (wb_addr != 5'd0) && (int'(wb_addr) < NREGS)) begin
            regs[wb_addr[AW-1:0]] <= wb_data;
        end
    end

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    always_comb begin
        rs1_val = '0;
        if ((rs1 != 5'd0) && (int'(rs1) < NREGS)) begin
            if (BYPASS_EN && wb_we && (wb_addr == rs1)) begin
                rs1_val = wb_data;
            end else begin
                rs1_val = regs[rs1[AW-1:0]];
            end
        end
    end

    always_comb begin
        rs2_val = '0;
        if ((rs2 != 5'd0) && (int'(rs2) < NREGS)) begin
            if (BYPASS_EN && wb_we && (wb_addr == rs2)) begin
                rs2_val = wb_data;
            end else begin
                rs2_val = regs[rs2[AW-1:0]];
            end
        end
    end

    // ------------------------------------------------------------------
    // Hazard detection and JAL redirect
    // ------------------------------------------------------------------
    // The load in EX is known from the registered ID/EX state; the bubble it
    // creates clears ex_valid, so the stall lasts exactly one cycle.
    assign stall_out = reset_n && if_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                       ((ex_rd == rs1) || (uses_rs2 && (ex_rd == rs2)));

    assign jump_taken  = reset_n && if_valid && (opcode == OP_JAL) && !stall_out && !ex_flush;
    assign jump_target = if_pc + sext(imm_j);

    // ------------------------------------------------------------------
    // ID/EX register
    // ------------------------------------------------------------------
    ctrl_t ctrl_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ctrl_q      <= '0;
            ex_illegal  <= 1'b0;
        end else begin
            // Datapath fields always load; valid and control decide whether they matter.
            ex_pc       <= if_pc;
            ex_rs1_data <= rs1_val;
            ex_rs2_data <= rs2_val;
            ex_imm      <= sext(imm_sel);
            ex_rs1      <= rs1;
            ex_rs2      <= rs2;
            ex_rd       <= rd;
            if (ex_flush || stall_out || !if_valid) begin
                ex_valid   <= 1'b0;
                ctrl_q     <= '0;
                ex_illegal <= 1'b0;
            end else begin
                ex_valid   <= 1'b1;
                ctrl_q     <= ctrl_d;
                ex_illegal <= illegal_op || bad_idx;
            end
        end
    end

    assign ex_mem_read = ctrl_q.mem_read;
    assign ctrl_wb     = {ctrl_q.mem_to_reg, ctrl_q.reg_write};
    assign ctrl_m      = {ctrl_q.mem_read, ctrl_q.mem_write};
    assign ctrl_ex     = {ctrl_q.alu_src, ctrl_q.alu_op};

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised instruction-decode stage for the RV pipeline, between the IF/ID register and EX.
- Contains the register file (x0 hardwired to zero) with optional WB write-through and full immediate generation (I/S/B/U/J).
- Generates control, detects load-use hazards, resolves JAL in ID, and owns the ID/EX pipeline register with bubble/flush insertion.

Parameters:
- XLEN, 64, datapath width. Legal values: 32 or 64.
- NREGS, 32, architectural register count. Legal values: 16 (RV-E) or 32.
- BYPASS_EN, 1, when 1, a WB write to the register being read in the same cycle is forwarded to the read.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- if_valid  in  1  if_instr/if_pc hold a real instruction.
- if_pc  in  XLEN  PC of the instruction in ID.
- if_instr  in  32  instruction word.
- wb_we  in  1  register-file write enable from WB.
- wb_addr  in  5  WB destination register.
- wb_data  in  XLEN  WB write data.
- ex_flush  in  1  branch/JALR mispredict from EX; kill the instruction in ID.
- stall_out  out  1  hold PC and IF/ID.
- jump_taken  out  1  JAL redirect (combinational).
- jump_target  out  XLEN  if_pc + J-immediate.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_pc  out  XLEN  registered PC.
- ex_rs1_data  out  XLEN  registered rs1 operand.
- ex_rs2_data  out  XLEN  registered rs2 operand.
- ex_imm  out  XLEN  sign-extended immediate.
- ex_rs1  out  5  registered rs1 index.
- ex_rs2  out  5  registered rs2 index.
- ex_rd  out  5  registered rd index.
- ex_mem_read  out  1  registered MemRead; also fed back for hazard detection.
- ctrl_wb  out  2  {MemtoReg, RegWrite}.
- ctrl_m  out  2  {MemRead, MemWrite}; bit 1 equals ex_mem_read.
- ctrl_ex  out  4  {ALUSrc, ALUOp[2:0]}.
- ex_illegal  out  1  registered illegal-instruction flag.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - All ID/EX outputs clear to 0, including ex_valid.
  - All NREGS registers clear to 0.
  - stall_out and jump_taken are 0 while in reset.
- ALUOp encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLL, 101 SLT.
- Decode {ctrl_wb, ctrl_m, ctrl_ex}:
  - R-type 0110011: 01_00_0, ALUOp from funct3/funct7. SUB = funct7[5]=1 with funct3=000.
  - ADDI 0010011: 01_00_1_000.
  - LD 0000011: 11_10_1_000.
  - SD 0100011: 00_01_1_000.
  - Branch 1100011: 00_00_0_001.
  - JALR 1100111: 01_00_1_000.
  - JAL 1101111: 01_00_0_000.
  - Any other opcode: all control bits 0, ex_illegal=1.
- Immediates are sign-extended to XLEN per the RV formats; B and J immediates include bit0=0.
- Register read:
  - Index 0 reads 0.
  - With BYPASS_EN=1, wb_we=1 and wb_addr==rs!=0, the read returns wb_data.
  - An index >= NREGS sets ex_illegal.
- Register write: on the clock edge when wb_we=1, wb_addr!=0 and wb_addr<NREGS.
- Load-use hazard:
  - stall_out = if_valid & ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==rs1 | (uses_rs2 & ex_rd==rs2)).
  - uses_rs2 is 1 for R, S and B formats only.
- Per-edge priority for the ID/EX register:
  1. ex_flush=1: ex_valid<=0, all control bits<=0.
  2. stall_out=1: bubble (ex_valid<=0, control<=0). The instruction stays in ID and is re-decoded next cycle.
  3. Otherwise: ex_valid<=if_valid and all fields load. Control is zeroed when if_valid=0.
- jump_taken = if_valid & opcode==JAL & !stall_out & !ex_flush. Asserted for exactly the cycle in which the JAL advances to EX.
- Stall latency: a load-use pair costs exactly one bubble. The next cycle sees ex_mem_read=0, stall drops, and the consumer reads the forwarded/WB value later.
- Simultaneous stall and ex_flush: flush wins and stall_out is still driven; IF discards under its own flush.
- Reset mid-stall: everything clears, with no residual bubble state.
- Width rule: jump_target wraps modulo 2^XLEN.

Test Plan:
- Reset, then ADDI x5,x0,-1 (0xFFF00293) with if_valid=1: after 1 edge, ex_imm=all-ones, ctrl_wb=01, ctrl_ex=1000, ex_rd=5, ex_valid=1.
- wb_we=1, wb_addr=3, wb_data=0x1234 in the same cycle as ADD x4,x3,x0 (BYPASS_EN=1): ex_rs1_data=0x1234. A write with wb_addr=0 leaves x0 reading 0.
- LD x7,0(x1) followed by ADD x8,x7,x2: stall_out=1 for one cycle, one bubble (ex_valid=0), then the ADD issues with ex_rs1=7.
- JAL x1,+16 at if_pc=0x100: jump_taken=1, jump_target=0x110, ex_ctrl_wb=01.
- JAL with ex_flush=1 in the same cycle: jump_taken=0, ex_valid=0 after the edge.
- Opcode 0x7F: ex_illegal=1, all control bits 0. NREGS=16 with rs1=20: ex_illegal=1.
